axi_lite_mem_responder: RTL and testbench
=========================================

// Module: axi_lite_mem_responder
// PURPOSE
//  AXI4-Lite slave memory model placed directly downstream of the picorv32_axi master port in benches.
//  Services AW/W/B and AR/R with word-addressed storage and byte-lane write strobes.
//  Response latency is parameterisable; per-channel stall inputs let formal/sim benches vary timing.
//  Exposes transaction counters for bench scoreboards and lockstep comparison.
// PARAMETERS
//  MEM_WORDS   1024  storage depth in 32-bit words (power of two); address index = addr[log2(MEM_WORDS)+1:2]
//  WR_LATENCY  0     extra cycles between write commit and bvalid (0..15)
//  RD_LATENCY  0     extra cycles between AR handshake and rvalid (0..15)
// PORTS
//  clk              in   1   clock
//  resetn           in   1   reset, synchronous, active-low
//  mem_axi_awvalid  in   1   write address valid
//  mem_axi_awready  out  1   write address ready
//  mem_axi_awaddr   in   32  write byte address
//  mem_axi_awprot   in   3   ignored
//  mem_axi_wvalid   in   1   write data valid
//  mem_axi_wready   out  1   write data ready
//  mem_axi_wdata    in   32  write data
//  mem_axi_wstrb    in   4   byte enables, bit i -> wdata[8i+7:8i]
//  mem_axi_bvalid   out  1   write response valid
//  mem_axi_bready   in   1   write response ready
//  mem_axi_arvalid  in   1   read address valid
//  mem_axi_arready  out  1   read address ready
//  mem_axi_araddr   in   32  read byte address
//  mem_axi_arprot   in   3   ignored
//  mem_axi_rvalid   out  1   read data valid
//  mem_axi_rready   in   1   read data ready
//  mem_axi_rdata    out  32  read data
//  stall_aw/stall_w/stall_ar  in 1 each  force corresponding ready low this cycle
//  wr_count, rd_count         out 16 each  completed B / R handshakes, wrap 0xFFFF->0
// BEHAVIOUR
//  Reset (resetn low at posedge): aw_full=w_full=ar_busy=0, bvalid=rvalid=0, rdata=0, counters=0; memory array NOT cleared.
//  While resetn low, all readies forced 0 combinationally.
//  Readies are combinational: awready=!aw_full&!stall_aw; wready=!w_full&!stall_w; arready=!ar_busy&!stall_ar.
//  Write path: AW and W captured independently into holding regs (address, data, strb) on their handshakes; either order, or same cycle.
//  Commit: first cycle with aw_full&w_full and no B pending -> update strobed bytes; load wr latency counter with WR_LATENCY.
//  bvalid rises when the counter reaches 0: 1 cycle after commit for latency 0, WR_LATENCY+1 cycles otherwise.
//  bvalid held until bvalid&bready; that cycle clears aw_full, w_full, bvalid and increments wr_count.
//  A new AW/W is accepted only after this clear, so one write is outstanding at a time.
//  Read path: on AR handshake, capture index, set ar_busy, load rd latency counter with RD_LATENCY.
//  When the counter reaches 0: rvalid=1 and rdata=mem[index] sampled that cycle; rvalid rises 1+RD_LATENCY cycles after the AR handshake.
//  rdata is stable while rvalid is high; on rvalid&rready clear rvalid and ar_busy, increment rd_count. rdata keeps its last value.
//  Simultaneous write commit and read sample to the same index: the read returns pre-commit data (array read before write in the same cycle).
//  Address bits above the index and addr[1:0] are ignored, so out-of-range addresses alias (wrap) modulo MEM_WORDS.
//  Read and write channels are fully independent; B and R may complete in the same cycle.
//  Stall inputs affect only readies; they never retract bvalid/rvalid nor alter data.
//  Reset mid-transaction abandons all pending AW/W/AR/B/R state. A write whose commit cycle has passed stays in memory.
// STRUCTURE
//  Shared package/header: AXI-Lite response code OKAY=2'b00 (reserved for future bresp/rresp), latency counter width LAT_W=4.
//  One sub-module, axi_lite_lat_ctr (load/count-down/done), instantiated twice (write and read paths).
//  Memory is a plain reg array with byte-lane write; no reset loop.
// TESTING
//  1 Reset then AW(0x10) and W(0xDEADBEEF, strb 0xF) same cycle, bready=1, WR_LATENCY=0 -> bvalid 1 cycle after commit, wr_count=1.
//  2 AR(0x10), rready=1, RD_LATENCY=3 -> rvalid exactly 4 cycles after the AR handshake, rdata=0xDEADBEEF, rd_count=1.
//  3 W(0x000000AA, strb 0x1) three cycles before AW(0x10), then read 0x10 -> rdata=0xDEADBEAA.
//  4 rready=0 for 5 cycles with rvalid high -> rdata and rvalid stable; stall_ar=1 -> arready=0, rvalid unchanged.
//  5 Write 0x11111111 at 0x0, read 4*MEM_WORDS -> rdata=0x11111111 (alias wrap).
//  6 resetn low for 1 cycle while bvalid pending -> bvalid=0, counters=0 next cycle; earlier committed data still readable.

Source files
------------

// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared types and constants for the AXI4-Lite memory responder.
`timescale 1ns/1ps
package axi_lite_mem_responder_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } wbeat_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_mem_responder_lat.sv
// Load/count-down latency timer; done pulses in the cycle a response should be registered.
`timescale 1ns/1ps
module axi_lite_lat_ctr
  import axi_lite_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             done
);

  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // Zero latency fires in the load cycle itself; otherwise fire when the count sits at 1.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (load) begin
      if (load_val == '0) begin
        done = 1'b1;
      end else begin
        active_d = 1'b1;
        cnt_d    = load_val;
      end
    end else if (active_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == LAT_W'(1)) begin
        done     = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave memory model with byte-strobed writes, response latency and stall hooks.
`timescale 1ns/1ps
module axi_lite_mem_responder
  import axi_lite_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned WR_LATENCY = 0,
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  input  logic        stall_aw,
  input  logic        stall_w,
  input  logic        stall_ar,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic             aw_full_q, aw_full_d;
  logic             w_full_q, w_full_d;
  logic             b_pend_q, b_pend_d;
  logic             bvalid_q, bvalid_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  wbeat_t           wbeat_q, wbeat_d;
  logic             ar_busy_q, ar_busy_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [IDX_W-1:0] ar_idx_q, ar_idx_d;
  logic [15:0]      wr_count_q, wr_count_d;
  logic [15:0]      rd_count_q, rd_count_d;

  logic             aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
  logic             wr_done, rd_done;
  logic [IDX_W-1:0] rd_idx;

  assign mem_axi_awready = resetn & ~aw_full_q & ~stall_aw;
  assign mem_axi_wready  = resetn & ~w_full_q  & ~stall_w;
  assign mem_axi_arready = resetn & ~ar_busy_q & ~stall_ar;
  assign mem_axi_bvalid  = bvalid_q;
  assign mem_axi_rvalid  = rvalid_q;
  assign mem_axi_rdata   = rdata_q;
  assign wr_count        = wr_count_q;
  assign rd_count        = rd_count_q;

  assign aw_hs  = mem_axi_awvalid & mem_axi_awready;
  assign w_hs   = mem_axi_wvalid  & mem_axi_wready;
  assign ar_hs  = mem_axi_arvalid & mem_axi_arready;
  assign b_hs   = bvalid_q & mem_axi_bready;
  assign r_hs   = rvalid_q & mem_axi_rready;
  assign commit = resetn & aw_full_q & w_full_q & ~b_pend_q;
  // With zero read latency the sample happens in the AR handshake cycle, before ar_idx_q is loaded.
  assign rd_idx = ar_hs ? mem_axi_araddr[IDX_W+1:2] : ar_idx_q;

  axi_lite_lat_ctr u_wr_lat (
    .clk      (clk),
    .resetn   (resetn),
    .load     (commit),
    .load_val (LAT_W'(WR_LATENCY)),
    .done     (wr_done)
  );

  axi_lite_lat_ctr u_rd_lat (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ar_hs),
    .load_val (LAT_W'(RD_LATENCY)),
    .done     (rd_done)
  );

  always_comb begin
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    b_pend_d   = b_pend_q;
    bvalid_d   = bvalid_q;
    aw_idx_d   = aw_idx_q;
    wbeat_d    = wbeat_q;
    ar_busy_d  = ar_busy_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    ar_idx_d   = ar_idx_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = mem_axi_awaddr[IDX_W+1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wbeat_d  = '{data: mem_axi_wdata, strb: mem_axi_wstrb};
    end
    if (commit)  b_pend_d = 1'b1;
    if (wr_done) bvalid_d = 1'b1;
    if (b_hs) begin
      aw_full_d  = 1'b0;
      w_full_d   = 1'b0;
      b_pend_d   = 1'b0;
      bvalid_d   = 1'b0;
      wr_count_d = wr_count_q + 16'd1;
    end

    if (ar_hs) begin
      ar_busy_d = 1'b1;
      ar_idx_d  = mem_axi_araddr[IDX_W+1:2];
    end
    if (rd_done) begin
      rvalid_d = 1'b1;
      rdata_d  = mem[rd_idx];
    end
    if (r_hs) begin
      rvalid_d   = 1'b0;
      ar_busy_d  = 1'b0;
      rd_count_d = rd_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      aw_idx_q   <= '0;
      wbeat_q    <= '0;
      ar_busy_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      ar_idx_q   <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      b_pend_q   <= b_pend_d;
      bvalid_q   <= bvalid_d;
      aw_idx_q   <= aw_idx_d;
      wbeat_q    <= wbeat_d;
      ar_busy_q  <= ar_busy_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ar_idx_q   <= ar_idx_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  // Storage is never reset; a same-cycle read samples the pre-commit word.
  always_ff @(posedge clk) begin
    if (commit) mem[aw_idx_q] <= merge_bytes(mem[aw_idx_q], wbeat_q.data, wbeat_q.strb);
  end

  logic unused_ok;
  assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot,
                       mem_axi_awaddr[31:IDX_W+2], mem_axi_awaddr[1:0],
                       mem_axi_araddr[31:IDX_W+2], mem_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder (WR_LATENCY=0, RD_LATENCY=3, MEM_WORDS=1024).
`timescale 1ns/1ps
module tb_axi_lite_mem_responder;

  localparam int unsigned MW = 1024;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic        stall_aw = 1'b0, stall_w = 1'b0, stall_ar = 1'b0;
  logic [15:0] wr_count, rd_count;

  int errors = 0;
  int checks = 0;

  axi_lite_mem_responder #(.MEM_WORDS(MW), .WR_LATENCY(0), .RD_LATENCY(3)) dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
    .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .stall_aw(stall_aw), .stall_w(stall_w), .stall_ar(stall_ar),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 40 && bvalid !== 1'b1; i++) tick();
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_b_timeout addr=%h bvalid=%b required 1", a, bvalid);
    end
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 40 && rvalid !== 1'b1; i++) tick();
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_r_timeout addr=%h rvalid=%b required 1", a, rvalid);
    end
    d = rdata;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got=%b exp=0", bvalid); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", wr_count, rd_count); end
    checks++; if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_readies got=%b exp=000", {awready, wready, arready}); end
    resetn = 1'b1;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL idle_readies got=%b exp=111", {awready, wready, arready}); end
  endtask

  task automatic test_write_same_cycle();
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (awready !== 1'b0 || wready !== 1'b0) begin
      errors++; $display("FAIL t1_held_readies got=%b%b exp=00", awready, wready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL t1_bvalid_commit_cycle got=%b exp=0", bvalid); end
    tick();
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL t1_bvalid_after_commit got=%b exp=1", bvalid); end
    tick();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL t1_bvalid_cleared got=%b exp=0", bvalid); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL t1_wr_count got=%0d exp=1", wr_count); end
  endtask

  task automatic test_read_latency();
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (rvalid !== 1'b0) begin
        errors++; $display("FAIL t2_rvalid_early cycle=%0d got=%b exp=0", i, rvalid); end
      if (i < 3) tick();
    end
    tick();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL t2_rvalid_on_time got=%b exp=1", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_rdata got=%h exp=deadbeef", rdata); end
    tick();
    checks++; if (rvalid !== 1'b0 || rd_count !== 16'd1) begin
      errors++; $display("FAIL t2_r_done got rvalid=%b rd_count=%0d exp 0/1", rvalid, rd_count); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL t3_wready_held got=%b exp=0", wready); end
    tick(); tick();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL t3_no_commit_without_aw got=%b exp=0", bvalid); end
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 40 && bvalid !== 1'b1; i++) tick();
    tick();
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL t3_wr_count got=%0d exp=2", wr_count); end
    do_read(32'h10, d);
    checks++; if (d !== 32'hDEADBEAA) begin errors++; $display("FAIL t3_merged_rdata got=%h exp=deadbeaa", d); end
  endtask

  task automatic test_read_backpressure();
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 40 && rvalid !== 1'b1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEAA) begin
        errors++; $display("FAIL t4_hold cycle=%0d got rvalid=%b rdata=%h exp 1/deadbeaa", i, rvalid, rdata); end
    end
    stall_ar = 1'b1;
    #1;
    checks++; if (arready !== 1'b0 || rvalid !== 1'b1) begin
      errors++; $display("FAIL t4_stall_busy got arready=%b rvalid=%b exp 0/1", arready, rvalid); end
    rready = 1'b1;
    tick();
    checks++; if (rvalid !== 1'b0 || rd_count !== 16'd3) begin
      errors++; $display("FAIL t4_r_done got rvalid=%b rd_count=%0d exp 0/3", rvalid, rd_count); end
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL t4_stall_idle got=%b exp=0", arready); end
    stall_ar = 1'b0; stall_aw = 1'b1;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b011) begin
      errors++; $display("FAIL t4_stall_aw got=%b exp=011", {awready, wready, arready}); end
    stall_aw = 1'b0; stall_w = 1'b1;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b101) begin
      errors++; $display("FAIL t4_stall_w got=%b exp=101", {awready, wready, arready}); end
    stall_w = 1'b0;
    #1;
  endtask

  task automatic test_alias();
    logic [31:0] d;
    do_write(32'h0, 32'h11111111, 4'hF);
    do_read(4 * MW, d);
    checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL t5_alias_rdata got=%h exp=11111111", d); end
    checks++; if (wr_count !== 16'd3 || rd_count !== 16'd4) begin
      errors++; $display("FAIL t5_counts got=%0d/%0d exp=3/4", wr_count, rd_count); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    awaddr = 32'h20; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 40 && bvalid !== 1'b1; i++) tick();
    tick();
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL t6_bvalid_held got=%b exp=1", bvalid); end
    resetn = 1'b0;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL t6_readies_in_reset got=%b exp=000", {awready, wready, arready}); end
    tick();
    resetn = 1'b1;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL t6_bvalid_reset got=%b exp=0", bvalid); end
    checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      errors++; $display("FAIL t6_counts_reset got=%0d/%0d exp=0/0", wr_count, rd_count); end
    bready = 1'b1;
    do_read(32'h20, d);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL t6_committed_kept got=%h exp=cafef00d", d); end
    do_read(32'h10, d);
    checks++; if (d !== 32'hDEADBEAA) begin errors++; $display("FAIL t6_old_data_kept got=%h exp=deadbeaa", d); end
    checks++; if (rd_count !== 16'd2 || wr_count !== 16'd0) begin
      errors++; $display("FAIL t6_counts_after got=%0d/%0d exp=0/2", wr_count, rd_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_same_cycle();
    test_read_latency();
    test_w_before_aw();
    test_read_backpressure();
    test_alias();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
